// File: rtl/nanorv32_irq_seq.sv
// -----------------------------------------------------------------------------
// nanorv32_irq_seq
//
// Interrupt sequencer for the nanorv32 flow controller. It ranks the enabled
// level IRQ sources (lowest index wins) and raises irq_req while idle. When the
// flow controller reports an instruction boundary, it takes the interrupt and
// walks the micro-ROM through the ENTRY sequence. It then holds in HANDLER
// until a RETI is qualified at a boundary, and finally walks the EXIT sequence.
//
// Ports
//   clk          core clock
//   rst          asynchronous active-high reset
//   irq_src      level interrupt sources            [NB_IRQ]
//   irq_en       per-source enable                  [NB_IRQ]
//   at_boundary  current cycle is an instruction boundary
//   inst_accept  micro-ROM instruction consumed this cycle
//   reti_detect  decoded RETI instruction
//   irq_req      enabled IRQ pending while idle (combinational)
//   irq_ack      one-hot, single-cycle pulse on the taken source [NB_IRQ]
//   irq_id       index of the latched source        [5]
//   urom_addr    micro-ROM address                  [UROM_ADDR_W]
//   urom_valid   bypass the instruction register with micro-ROM data
//   in_irq       interrupt state (qualifies RETI in the flow controller)
// -----------------------------------------------------------------------------
module nanorv32_irq_seq #(
    parameter int NB_IRQ      = 8,
    parameter int UROM_ADDR_W = 5,
    parameter int ENTRY_ADDR  = 0,
    parameter int ENTRY_LEN   = 4,
    parameter int EXIT_ADDR   = 8,
    parameter int EXIT_LEN    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NB_IRQ-1:0]      irq_src,
    input  logic [NB_IRQ-1:0]      irq_en,
    input  logic                   at_boundary,
    input  logic                   inst_accept,
    input  logic                   reti_detect,
    output logic                   irq_req,
    output logic [NB_IRQ-1:0]      irq_ack,
    output logic [4:0]             irq_id,
    output logic [UROM_ADDR_W-1:0] urom_addr,
    output logic                   urom_valid,
    output logic                   in_irq
);

    localparam int MAX_LEN = (ENTRY_LEN > EXIT_LEN) ? ENTRY_LEN : EXIT_LEN;
    // Keep the counter at least one bit wide when both sequences are one long.
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0]       ENTRY_LAST = CNT_W'(ENTRY_LEN - 1);
    localparam logic [CNT_W-1:0]       EXIT_LAST  = CNT_W'(EXIT_LEN - 1);
    localparam logic [UROM_ADDR_W-1:0] ENTRY_A    = UROM_ADDR_W'(ENTRY_ADDR);
    localparam logic [UROM_ADDR_W-1:0] EXIT_A     = UROM_ADDR_W'(EXIT_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        HANDLER,
        EXIT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [NB_IRQ-1:0] pend;
    logic [4:0]        winner;

    assign pend    = irq_src & irq_en;
    assign irq_req = (state == IDLE) && (|pend);

    // Fixed priority: scan from the top down so the lowest set index is the
    // last assignment and therefore wins.
    always_comb begin
        // NOTE: default first so every path assigns winner and no latch is inferred.
        winner = '0;
        for (int i = NB_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                winner = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            irq_id     <= '0;
            urom_addr  <= '0;
            irq_ack    <= '0;
            urom_valid <= 1'b0;
            in_irq     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            // The acknowledge is a single-cycle pulse; only the take cycle re-arms it.
            irq_ack <= '0;

            unique case (state)
                IDLE: begin
                    if ((|pend) && at_boundary) begin
                        irq_id     <= winner;
                        irq_ack    <= NB_IRQ'(1) << winner;
                        cnt        <= '0;
                        urom_addr  <= ENTRY_A;
                        urom_valid <= 1'b1;
                        state      <= ENTRY;
                    end
                end

                ENTRY: begin
                    // No accept means the flow controller stalled: hold everything.
                    if (inst_accept) begin
                        if (cnt == ENTRY_LAST) begin
                            urom_valid <= 1'b0;
                            in_irq     <= 1'b1;
                            state      <= HANDLER;
                        end else begin
                            cnt       <= cnt + CNT_W'(1);
                            urom_addr <= urom_addr + UROM_ADDR_W'(1);
                        end
                    end
                end

                HANDLER: begin
                    // Pending IRQs wait here; only a boundary-qualified RETI leaves.
                    if (reti_detect && at_boundary) begin
                        cnt        <= '0;
                        urom_addr  <= EXIT_A;
                        urom_valid <= 1'b1;
                        state      <= EXIT;
                    end
                end

                EXIT: begin
                    if (inst_accept) begin
                        if (cnt == EXIT_LAST) begin
                            urom_valid <= 1'b0;
                            in_irq     <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            cnt       <= cnt + CNT_W'(1);
                            urom_addr <= urom_addr + UROM_ADDR_W'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
